// File: rtl/zdram_pkg.sv
// Shared constants and helpers for the SDRAM slot arbiter.
package zdram_pkg;

  localparam int unsigned AW_DEF = 21;
  localparam int unsigned DW_DEF = 16;

  // Slot owner encoding
  localparam logic [1:0] SLOT_IDLE = 2'd0;
  localparam logic [1:0] SLOT_VID  = 2'd1;
  localparam logic [1:0] SLOT_CPU  = 2'd2;
  localparam logic [1:0] SLOT_DMA  = 2'd3;

  // Byte-enable encoding {hi,lo}
  localparam logic [1:0] BSEL_LO   = 2'b01;
  localparam logic [1:0] BSEL_HI   = 2'b10;
  localparam logic [1:0] BSEL_WORD = 2'b11;

  // True when exactly one slot phase strobe is high.
  function automatic logic phase_ok(input logic [3:0] ph);
    case (ph)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: phase_ok = 1'b1;
      default:                            phase_ok = 1'b0;
    endcase
  endfunction

  // Strict priority: video, then CPU, then DMA.
  function automatic logic [1:0] slot_grant(input logic vid, input logic cpu, input logic dma);
    if (vid)      slot_grant = SLOT_VID;
    else if (cpu) slot_grant = SLOT_CPU;
    else if (dma) slot_grant = SLOT_DMA;
    else          slot_grant = SLOT_IDLE;
  endfunction

endpackage

// File: rtl/zdram_rdret.sv
// Per-port read return: captures slot read data at c1, pulses a strobe
// during c2 and optionally holds a latch flag until the next slot's c1.
module zdram_rdret
  import zdram_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter bit          LATCH_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ph_ok_i,
  input  logic          c1_i,
  input  logic          rd_slot_i,
  input  logic [DW-1:0] rddata_i,
  output logic          strobe_o,
  output logic          latch_o,
  output logic [DW-1:0] rddata_o
);

  logic          strobe_q, strobe_d;
  logic          latch_q,  latch_d;
  logic [DW-1:0] data_q,   data_d;

  // Next-state: strobe lives one clk after c1; latch re-evaluated at every c1.
  always_comb begin
    strobe_d = strobe_q;
    latch_d  = latch_q;
    data_d   = data_q;
    if (ph_ok_i) begin
      strobe_d = 1'b0;
      if (c1_i) begin
        strobe_d = rd_slot_i;
        latch_d  = LATCH_EN & rd_slot_i;
        if (rd_slot_i) begin
          data_d = rddata_i;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      latch_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= strobe_d;
      latch_q  <= latch_d;
      data_q   <= data_d;
    end
  end

  assign strobe_o = strobe_q;
  assign latch_o  = latch_q;
  assign rddata_o = data_q;

endmodule

// File: rtl/zdram_arb.sv
// CPU/video/DMA slot arbiter in front of the SDRAM controller.
// A slot is four clocks (c0..c3); ownership is decided at c3 for the next slot.
module zdram_arb
  import zdram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0,
  input  logic          c1,
  input  logic          c2,
  input  logic          c3,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rnw,
  input  logic          cpu_wrbsel,
  input  logic [7:0]    cpu_wrdata,
  output logic          cpu_next,
  output logic          cpu_strobe,
  output logic          cpu_latch,
  output logic [DW-1:0] cpu_rddata,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_rnw,
  input  logic [DW-1:0] dma_wrdata,
  output logic          dma_next,
  output logic          dma_strobe,
  output logic [DW-1:0] dma_rddata,
  output logic          dram_req,
  output logic [AW-1:0] dram_addr,
  output logic          dram_rnw,
  output logic [1:0]    dram_bsel,
  output logic [DW-1:0] dram_wrdata,
  input  logic [DW-1:0] dram_rddata
);

  logic          ph_ok_c;
  logic [1:0]    grant_c;
  logic          cpu_rd_c;
  logic          dma_rd_c;
  logic          dma_latch_unused;

  logic [1:0]    owner_q,       owner_d;
  logic          dram_req_q,    dram_req_d;
  logic [AW-1:0] dram_addr_q,   dram_addr_d;
  logic          dram_rnw_q,    dram_rnw_d;
  logic [1:0]    dram_bsel_q,   dram_bsel_d;
  logic [DW-1:0] dram_wrdata_q, dram_wrdata_d;

  assign ph_ok_c = phase_ok({c3, c2, c1, c0});
  assign grant_c = slot_grant(vid_req, cpu_req, dma_req);

  // Look-ahead hints; forced low while in reset so every output reads 0.
  assign cpu_next = rst_n & ~vid_req;
  assign dma_next = rst_n & c3 & ~vid_req & ~cpu_req & dma_req;

  // Next-state: grant and command capture at c3, dram_req only during c0.
  always_comb begin
    owner_d       = owner_q;
    dram_req_d    = dram_req_q;
    dram_addr_d   = dram_addr_q;
    dram_rnw_d    = dram_rnw_q;
    dram_bsel_d   = dram_bsel_q;
    dram_wrdata_d = dram_wrdata_q;
    if (ph_ok_c) begin
      dram_req_d = 1'b0;
      if (c3) begin
        owner_d    = grant_c;
        dram_req_d = (grant_c != SLOT_IDLE);
        case (grant_c)
          SLOT_VID: begin
            dram_addr_d = vid_addr;
            dram_rnw_d  = 1'b1;
            dram_bsel_d = BSEL_WORD;
          end
          SLOT_CPU: begin
            dram_addr_d   = cpu_addr;
            dram_rnw_d    = cpu_rnw;
            dram_bsel_d   = cpu_rnw ? BSEL_WORD : (cpu_wrbsel ? BSEL_HI : BSEL_LO);
            dram_wrdata_d = DW'({2{cpu_wrdata}});
          end
          SLOT_DMA: begin
            dram_addr_d   = dma_addr;
            dram_rnw_d    = dma_rnw;
            dram_bsel_d   = BSEL_WORD;
            dram_wrdata_d = dma_wrdata;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Slot owner and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= SLOT_IDLE;
      dram_req_q    <= 1'b0;
      dram_addr_q   <= '0;
      dram_rnw_q    <= 1'b0;
      dram_bsel_q   <= 2'b00;
      dram_wrdata_q <= '0;
    end else begin
      owner_q       <= owner_d;
      dram_req_q    <= dram_req_d;
      dram_addr_q   <= dram_addr_d;
      dram_rnw_q    <= dram_rnw_d;
      dram_bsel_q   <= dram_bsel_d;
      dram_wrdata_q <= dram_wrdata_d;
    end
  end

  assign dram_req    = dram_req_q;
  assign dram_addr   = dram_addr_q;
  assign dram_rnw    = dram_rnw_q;
  assign dram_bsel   = dram_bsel_q;
  assign dram_wrdata = dram_wrdata_q;

  assign cpu_rd_c = (owner_q == SLOT_CPU) & dram_rnw_q;
  assign dma_rd_c = (owner_q == SLOT_DMA) & dram_rnw_q;

  zdram_rdret #(.DW(DW), .LATCH_EN(1'b1)) u_cpu_ret (
    .clk       (clk),
    .rst_n     (rst_n),
    .ph_ok_i   (ph_ok_c),
    .c1_i      (c1),
    .rd_slot_i (cpu_rd_c),
    .rddata_i  (dram_rddata),
    .strobe_o  (cpu_strobe),
    .latch_o   (cpu_latch),
    .rddata_o  (cpu_rddata)
  );

  zdram_rdret #(.DW(DW), .LATCH_EN(1'b0)) u_dma_ret (
    .clk       (clk),
    .rst_n     (rst_n),
    .ph_ok_i   (ph_ok_c),
    .c1_i      (c1),
    .rd_slot_i (dma_rd_c),
    .rddata_i  (dram_rddata),
    .strobe_o  (dma_strobe),
    .latch_o   (dma_latch_unused),
    .rddata_o  (dma_rddata)
  );

endmodule

// File: tb/tb_zdram_arb.sv
// Bench for zdram_arb: directed vector table plus randomized run against
// a slot-level reference model.
module tb_zdram_arb;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 16;
  localparam int NR = 800;

  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b1000;

  localparam logic [20:0] CA = 21'h00123;
  localparam logic [20:0] DA = 21'h0ABCD;
  localparam logic [20:0] VA = 21'h1F000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          c0, c1, c2, c3;
  logic          vid_req, cpu_req, cpu_rnw, cpu_wrbsel, dma_req, dma_rnw;
  logic [AW-1:0] vid_addr, cpu_addr, dma_addr;
  logic [7:0]    cpu_wrdata;
  logic [DW-1:0] dma_wrdata, dram_rddata;
  logic          cpu_next, cpu_strobe, cpu_latch, dma_next, dma_strobe;
  logic [DW-1:0] cpu_rddata, dma_rddata, dram_wrdata;
  logic          dram_req, dram_rnw;
  logic [AW-1:0] dram_addr;
  logic [1:0]    dram_bsel;

  zdram_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
    .cpu_rddata(cpu_rddata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw),
    .dma_wrdata(dma_wrdata), .dma_next(dma_next), .dma_strobe(dma_strobe),
    .dma_rddata(dma_rddata),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_rnw(dram_rnw),
    .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata), .dram_rddata(dram_rddata)
  );

  typedef struct {
    logic [3:0]  ph;
    logic        rstn, vid, cpu, crnw, cbs, dma, drnw;
    logic [15:0] rdd;
    logic        req, cstb, clat, dstb, cnext, dnext;
    logic [20:0] addr;
    logic        rnw;
    logic [1:0]  bsel;
    logic [15:0] wrd, crd;
  } vec_t;

  typedef enum int {OWN_NONE, OWN_VIDEO, OWN_CPU, OWN_DMA} own_e;

  vec_t        vecs[$];
  logic [20:0] b_addr;
  logic        b_rnw;
  logic [1:0]  b_bsel;
  logic [15:0] b_wrd, b_crd;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", nm, cur, act, exp);
    end
  endtask

  task automatic cmd(input logic [20:0] a, input logic r, input logic [1:0] b, input logic [15:0] w);
    b_addr = a; b_rnw = r; b_bsel = b; b_wrd = w;
  endtask

  task automatic add(input logic [3:0] ph, input logic rstn, input logic vid, input logic cpu,
                     input logic crnw, input logic cbs, input logic dma, input logic drnw,
                     input logic [15:0] rdd, input logic req, input logic cstb, input logic clat,
                     input logic dstb, input logic cnext, input logic dnext);
    vec_t v;
    v.ph = ph; v.rstn = rstn; v.vid = vid; v.cpu = cpu; v.crnw = crnw; v.cbs = cbs;
    v.dma = dma; v.drnw = drnw; v.rdd = rdd;
    v.req = req; v.cstb = cstb; v.clat = clat; v.dstb = dstb; v.cnext = cnext; v.dnext = dnext;
    v.addr = b_addr; v.rnw = b_rnw; v.bsel = b_bsel; v.wrd = b_wrd; v.crd = b_crd;
    vecs.push_back(v);
  endtask

  // Reference-model state for the random run
  bit          e_req[NR+8], e_cstb[NR+8], e_clat[NR+8], e_dstb[NR+8];
  logic [20:0] m_addr;
  logic        m_rnw;
  logic [1:0]  m_bsel;
  logic [15:0] m_wrd, m_crd, m_drd;
  own_e        s_own, g;
  logic        s_rnw;
  int          ph;

  initial begin
    rst_n = 1'b0; {c3, c2, c1, c0} = P0;
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_rnw = 1'b1; cpu_wrbsel = 1'b0; dma_rnw = 1'b1;
    vid_addr = VA; cpu_addr = CA; dma_addr = DA;
    cpu_wrdata = 8'hA5; dma_wrdata = 16'h1234; dram_rddata = '0;

    // ---------------- directed table ----------------
    // args: ph rstn vid cpu crnw cbs dma drnw rdd | req cstb clat dstb cnext dnext
    cmd(21'h0, 1'b0, 2'b00, 16'h0); b_crd = 16'h0;
    add(P0, 0, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 0, 0);
    add(P1, 0, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 0, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    add(P3, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    cmd(CA, 1'b1, 2'b11, 16'hA5A5);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'hBEEF,  0, 0, 0, 0, 1, 0);
    b_crd = 16'hBEEF;
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 1, 1, 0, 1, 0);
    add(P3, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    // video and CPU collide: video wins
    add(P3, 1, 1, 1, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 0, 0);
    cmd(VA, 1'b1, 2'b11, 16'hA5A5);
    add(P0, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 1, 1, 0, 0, 1, 16'h5555,  0, 0, 0, 0, 1, 0);
    add(P2, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    // CPU write, high byte
    add(P3, 1, 0, 1, 0, 1, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    cmd(CA, 1'b0, 2'b10, 16'hA5A5);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h7777,  0, 0, 0, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    // DMA write
    add(P3, 1, 0, 0, 1, 0, 1, 0, 16'h0000,  0, 0, 0, 0, 1, 1);
    cmd(DA, 1'b0, 2'b11, 16'h1234);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 1, 0, 16'h9999,  0, 0, 0, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    // back-to-back CPU reads (DMA also asking, loses)
    add(P3, 1, 0, 1, 1, 0, 1, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    cmd(CA, 1'b1, 2'b11, 16'hA5A5);
    add(P0, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h1111,  0, 0, 0, 0, 1, 0);
    b_crd = 16'h1111;
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 1, 1, 0, 1, 0);
    add(P3, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 1, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h2222,  0, 0, 1, 0, 1, 0);
    b_crd = 16'h2222;
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 1, 1, 0, 1, 0);
    add(P3, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    // phase violations hold state
    add(P3, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    add(4'b0000, 1, 0, 0, 1, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 0);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h3333,  0, 0, 0, 0, 1, 0);
    b_crd = 16'h3333;
    add(4'b0110, 1, 0, 0, 1, 0, 0, 1, 16'h0000, 0, 1, 1, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 1, 1, 0, 1, 0);
    add(P3, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 1, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h4444,  0, 0, 1, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    // reset at c1 of a CPU read slot
    add(P3, 1, 0, 1, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    cmd(21'h0, 1'b0, 2'b00, 16'h0); b_crd = 16'h0;
    add(P1, 0, 0, 0, 1, 0, 0, 1, 16'h5A5A,  0, 0, 0, 0, 0, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    add(P3, 1, 0, 1, 0, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);
    cmd(CA, 1'b0, 2'b01, 16'hA5A5);
    add(P0, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  1, 0, 0, 0, 1, 0);
    add(P1, 1, 0, 0, 1, 0, 0, 1, 16'h6666,  0, 0, 0, 0, 1, 0);
    add(P2, 1, 0, 0, 1, 0, 0, 1, 16'h0000,  0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      cur = i;
      {c3, c2, c1, c0} = vecs[i].ph;
      rst_n = vecs[i].rstn; vid_req = vecs[i].vid; cpu_req = vecs[i].cpu;
      cpu_rnw = vecs[i].crnw; cpu_wrbsel = vecs[i].cbs;
      dma_req = vecs[i].dma; dma_rnw = vecs[i].drnw; dram_rddata = vecs[i].rdd;
      #1;
      chk("dram_req",    32'(dram_req),    32'(vecs[i].req));
      chk("cpu_strobe",  32'(cpu_strobe),  32'(vecs[i].cstb));
      chk("cpu_latch",   32'(cpu_latch),   32'(vecs[i].clat));
      chk("dma_strobe",  32'(dma_strobe),  32'(vecs[i].dstb));
      chk("cpu_next",    32'(cpu_next),    32'(vecs[i].cnext));
      chk("dma_next",    32'(dma_next),    32'(vecs[i].dnext));
      chk("dram_addr",   32'(dram_addr),   32'(vecs[i].addr));
      chk("dram_rnw",    32'(dram_rnw),    32'(vecs[i].rnw));
      chk("dram_bsel",   32'(dram_bsel),   32'(vecs[i].bsel));
      chk("dram_wrdata", 32'(dram_wrdata), 32'(vecs[i].wrd));
      chk("cpu_rddata",  32'(cpu_rddata),  32'(vecs[i].crd));
    end

    // ---------------- randomized run ----------------
    @(posedge clk); #1;
    rst_n = 1'b0; {c3, c2, c1, c0} = P0;
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    cur = -1;
    chk("rst_dma_rddata", 32'(dma_rddata), 32'h0);
    chk("rst_dram_req",   32'(dram_req),   32'h0);
    chk("rst_cpu_next",   32'(cpu_next),   32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int t = 0; t < NR + 8; t++) begin
      e_req[t] = 1'b0; e_cstb[t] = 1'b0; e_clat[t] = 1'b0; e_dstb[t] = 1'b0;
    end
    m_addr = '0; m_rnw = 1'b0; m_bsel = 2'b00; m_wrd = '0; m_crd = '0; m_drd = '0;
    s_own = OWN_NONE; s_rnw = 1'b0;

    for (int t = 0; t < NR; t++) begin
      @(posedge clk); #1;
      cur = 1000 + t;
      ph = t % 4;
      c0 = (ph == 0); c1 = (ph == 1); c2 = (ph == 2); c3 = (ph == 3);
      vid_req = ($urandom_range(0, 3) == 0);
      cpu_req = 1'($urandom_range(0, 1));
      dma_req = 1'($urandom_range(0, 1));
      cpu_rnw = 1'($urandom_range(0, 1));
      dma_rnw = 1'($urandom_range(0, 1));
      cpu_wrbsel = 1'($urandom_range(0, 1));
      vid_addr = AW'($urandom); cpu_addr = AW'($urandom); dma_addr = AW'($urandom);
      cpu_wrdata = 8'($urandom); dma_wrdata = DW'($urandom); dram_rddata = DW'($urandom);
      #1;
      chk("rnd_dram_req",    32'(dram_req),    32'(e_req[t]));
      chk("rnd_dram_addr",   32'(dram_addr),   32'(m_addr));
      chk("rnd_dram_rnw",    32'(dram_rnw),    32'(m_rnw));
      chk("rnd_dram_bsel",   32'(dram_bsel),   32'(m_bsel));
      chk("rnd_dram_wrdata", 32'(dram_wrdata), 32'(m_wrd));
      chk("rnd_cpu_strobe",  32'(cpu_strobe),  32'(e_cstb[t]));
      chk("rnd_cpu_latch",   32'(cpu_latch),   32'(e_clat[t]));
      chk("rnd_cpu_rddata",  32'(cpu_rddata),  32'(m_crd));
      chk("rnd_dma_strobe",  32'(dma_strobe),  32'(e_dstb[t]));
      chk("rnd_dma_rddata",  32'(dma_rddata),  32'(m_drd));
      chk("rnd_cpu_next",    32'(cpu_next),    32'(!vid_req));
      chk("rnd_dma_next",    32'(dma_next),    32'((ph == 3) && !vid_req && !cpu_req && dma_req));

      // Slot decision at c3 applies to the slot starting next clk.
      if (ph == 3) begin
        if (vid_req)      g = OWN_VIDEO;
        else if (cpu_req) g = OWN_CPU;
        else if (dma_req) g = OWN_DMA;
        else              g = OWN_NONE;
        s_own = g;
        s_rnw = 1'b0;
        e_req[t+1] = (g != OWN_NONE);
        if (g == OWN_VIDEO) begin
          m_addr = vid_addr; m_rnw = 1'b1; m_bsel = 2'b11; s_rnw = 1'b1;
        end else if (g == OWN_CPU) begin
          m_addr = cpu_addr; m_rnw = cpu_rnw; s_rnw = cpu_rnw;
          m_bsel = cpu_rnw ? 2'b11 : (cpu_wrbsel ? 2'b10 : 2'b01);
          m_wrd  = {cpu_wrdata, cpu_wrdata};
        end else if (g == OWN_DMA) begin
          m_addr = dma_addr; m_rnw = dma_rnw; s_rnw = dma_rnw;
          m_bsel = 2'b11; m_wrd = dma_wrdata;
        end
      end
      // Read data arrives during c1 of the slot and is presented from c2.
      if (ph == 1 && s_rnw) begin
        if (s_own == OWN_CPU) begin
          m_crd = dram_rddata;
          e_cstb[t+1] = 1'b1;
          for (int k = 1; k <= 4; k++) e_clat[t+k] = 1'b1;
        end else if (s_own == OWN_DMA) begin
          m_drd = dram_rddata;
          e_dstb[t+1] = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
